// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream between the programming interface
// and the chain loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serial loader for the tile configuration chain (MSB first).
// Define CCFF_READBACK_EN to build the CRC readback/verify pass.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start,
    ccff_chain_loader_if.slave             cfg,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
`ifdef CCFF_READBACK_EN
        VERIFY,
`endif
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bits_left_q, bits_left_d;
    logic [CW-1:0]     count_q, count_d;

    logic in_load;
    logic shift_load;
    logic last_shift;
    logic accept;

    assign in_load    = (state_q == LOAD);
    assign shift_load = in_load && (bits_left_q != '0);
    assign last_shift = shift_load && (count_q == LAST_IDX);

    // Refill one cycle early so back-to-back words shift without a bubble;
    // nothing is taken on the final shift since it would be discarded.
    assign cfg.cfg_ready = in_load && !last_shift &&
                           ((bits_left_q == '0) ||
                            (bits_left_q == BW'(1)));
    assign accept = cfg.cfg_ready && cfg.cfg_valid;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign bit_count = count_q;

`ifdef CCFF_READBACK_EN
    logic [15:0] crc_load_q, crc_load_d;
    logic [15:0] crc_rb_q, crc_rb_d;
    logic        error_q, error_d;
    logic        in_verify;

    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign in_verify     = (state_q == VERIFY);
    assign ccff_shift_en = shift_load || in_verify;
    // Recirculate during verify so the chain ends up unchanged.
    assign ccff_head     = in_verify ? ccff_tail : shreg_q[WORD_W-1];
    assign error         = error_q;
`else
    logic unused_tail;

    assign unused_tail   = ccff_tail;
    assign ccff_shift_en = shift_load;
    assign ccff_head     = shreg_q[WORD_W-1];
    assign error         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        count_d     = count_q;
`ifdef CCFF_READBACK_EN
        crc_load_d  = crc_load_q;
        crc_rb_d    = crc_rb_q;
        error_d     = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    count_d     = '0;
                    bits_left_d = '0;
`ifdef CCFF_READBACK_EN
                    error_d     = 1'b0;
                    crc_load_d  = 16'hFFFF;
`endif
                end
            end
            LOAD: begin
                if (shift_load) begin
                    shreg_d     = shreg_q << 1;
                    bits_left_d = bits_left_q - BW'(1);
                    count_d     = count_q + CW'(1);
`ifdef CCFF_READBACK_EN
                    crc_load_d  = crc_step(crc_load_q,
                                           shreg_q[WORD_W-1]);
`endif
                end
                if (accept) begin
                    shreg_d     = cfg.cfg_data;
                    bits_left_d = BW'(WORD_W);
                end
                if (last_shift) begin
                    shreg_d     = '0;
                    bits_left_d = '0;
`ifdef CCFF_READBACK_EN
                    state_d     = VERIFY;
                    count_d     = '0;
                    crc_rb_d    = 16'hFFFF;
`else
                    state_d     = FINISH;
`endif
                end
            end
`ifdef CCFF_READBACK_EN
            VERIFY: begin
                count_d  = count_q + CW'(1);
                crc_rb_d = crc_step(crc_rb_q, ccff_tail);
                if (count_q == LAST_IDX) begin
                    error_d = (crc_rb_d != crc_load_q);
                    state_d = FINISH;
                end
            end
`endif
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            count_q     <= '0;
`ifdef CCFF_READBACK_EN
            crc_load_q  <= 16'hFFFF;
            crc_rb_q    <= 16'hFFFF;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            count_q     <= count_d;
`ifdef CCFF_READBACK_EN
            crc_load_q  <= crc_load_d;
            crc_rb_q    <= crc_rb_d;
            error_q     <= error_d;
`endif
        end
    end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream loader for the tile configuration chain. It accepts configuration words over a valid/ready stream and serializes them MSB-first onto the chain's `ccff_head`. It drives a shift-enable that the clock-gating cell at the fabric boundary uses to gate `prog_clk` into the chain. It sits between the programming interface and the first tile's `ccff_head`, and observes the last tile's `ccff_tail`.

## Interface
Parameters:
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; must be ≥ 2.
- `WORD_W`, default 8: width of input configuration words.

Ports:
- `prog_clk` in 1: single clock; the chain shifts on rising edges where `ccff_shift_en`=1.
- `prog_reset` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to begin a load; honoured only in IDLE.
- `cfg_data` in `WORD_W`: configuration word, MSB shifted first.
- `cfg_valid` in 1: `cfg_data` valid.
- `cfg_ready` out 1: word accepted on an edge where `cfg_valid`&`cfg_ready`.
- `ccff_head` out 1: serial bit into the chain.
- `ccff_shift_en` out 1: chain clock enable.
- `ccff_tail` in 1: serial bit out of the chain.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at completion.
- `error` out 1: readback CRC mismatch, sticky until next `start`.
- `bit_count` out `$clog2(CHAIN_LEN+1)`: bits shifted in the current pass.

## Operation
- States: IDLE, LOAD, VERIFY (present only with macro), FINISH.
- IDLE:
  - `start`=1 moves to LOAD.
  - Entry clears `bit_count`, the word buffer (`bits_left`=0), `error`, and the CRC (set to 0xFFFF).
- LOAD:
  - `cfg_ready` = (`bits_left`==0) | (`bits_left`==1 & `ccff_shift_en`). This allows zero-bubble back-to-back words.
  - On accept: `shreg`←`cfg_data`, `bits_left`←`WORD_W`.
  - `ccff_head` = `shreg[WORD_W-1]`; `ccff_shift_en` = (`bits_left`≠0).
  - Each shift edge: `shreg` shifts left, `bits_left`−1, `bit_count`+1, CRC updated with `ccff_head`.
  - No valid word pending: `ccff_shift_en`=0 (stall). The chain holds.
- Last bit:
  - The shift at `bit_count`==`CHAIN_LEN`−1 is the last one.
  - Remaining bits of the current word are discarded; `bits_left` is forced to 0 and `cfg_ready`=0 after it.
  - Next state is VERIFY if the macro is defined, otherwise FINISH.
- VERIFY:
  - `bit_count` restarts at 0. `ccff_shift_en`=1 every cycle and `ccff_head`=`ccff_tail` (recirculation), so chain contents are preserved after `CHAIN_LEN` shifts.
  - A second CRC accumulates `ccff_tail`.
  - After `CHAIN_LEN` shifts: `error`←(`crc_rb` ≠ `crc_load`); go to FINISH.
- FINISH: `done`=1 for this one cycle, then IDLE.
- `start` while `busy`: ignored.
- `cfg_valid` outside LOAD: ignored; `cfg_ready`=0.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, with the input bit XORed into `crc[15]`.
- Reset mid-operation: all state returns to reset values next edge. Chain contents are undefined and must be reloaded.

## Timing
- Reset values: `cfg_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `error`=0, `bit_count`=0, state IDLE.
- `start` edge → LOAD next cycle.
- First word accepted in LOAD → first shift-enabled cycle is the next cycle.
- `ccff_head` and `ccff_shift_en` decode only from registers, with no combinational path from inputs. `ccff_head` in VERIFY is a direct feedthrough of `ccff_tail`.
- Throughput: 1 bit/cycle. With `cfg_valid` held high, one word every `WORD_W` cycles.
- Latency without the macro: the `done` pulse comes 1 cycle after the final shift edge (FINISH).
- Latency with the macro: VERIFY adds `CHAIN_LEN` cycles. `done` and `error` are valid in the same cycle.

## Configuration
- Macro: `CCFF_READBACK_EN`.
- Defined: VERIFY state, both CRC registers, and recirculation mux are built. `error` is functional.
- Undefined: none of that logic exists. LOAD goes directly to FINISH, `error` is tied 0, and `ccff_head` is always `shreg` MSB.

## Test plan
- Basic load: `CHAIN_LEN`=16, `WORD_W`=8, words 0xA5, 0x3C back-to-back → 16 consecutive shift cycles, serial stream 1010_0101_0011_1100, `done` 1 cycle after the last shift, `bit_count`=16.
- Partial final word: `CHAIN_LEN`=20, words 0xFF, 0x00, 0xF0 → 20 shifts, last four bits 1111, bits 3:0 of 0xF0 dropped, `cfg_ready`=0 after the last shift.
- Stall: deassert `cfg_valid` for 5 cycles between words → `ccff_shift_en`=0 for exactly those cycles, stream unchanged.
- Readback (macro on): behavioural 20-bit chain model, load as in the partial-word test → `error`=0, chain contents equal the loaded pattern after FINISH. Flip one chain bit before VERIFY → `error`=1.
- Protocol abuse: `start` pulsed during LOAD and `cfg_valid` asserted in IDLE → no effect on state, `cfg_ready` stays 0 in IDLE.
- Reset mid-LOAD: `prog_reset`=0 at `bit_count`=7 → next edge all outputs at reset values. A new `start` reloads from `bit_count` 0.
